cdb_rr_multilane: RTL and testbench

- Parametrised common data bus arbiter that generalises the single-lane fixed-priority CDB.
- Accepts completion packets from NUM_FU functional units through valid/ready handshakes and buffers them in per-FU FIFOs.
- Broadcasts up to CDB_WIDTH packets per cycle on registered lanes, using rotating (round-robin) priority.
- Sits between the execution units and the RS, PRF, ROB and branch-recovery logic.

---
 rtl/cdb_rr_multilane.sv | 230 +++++++++++++++++++++++
 tb/tb_cdb_rr_multilane.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_rr_multilane.sv
// cdb_rr_multilane: multi-lane common data bus arbiter.
// Completion packets from NUM_FU functional units are buffered in per-FU FIFOs.
// Up to CDB_WIDTH head packets per cycle are broadcast on registered lanes.
// Lanes are granted in rotating (round-robin) order.
// Optional feature macro: CDB_BR_PRIORITY_EN. When it is defined, branch heads
// are granted ahead of non-branch heads.
module cdb_rr_multilane #(
    parameter int unsigned NUM_FU    = 4,
    parameter int unsigned CDB_WIDTH = 2,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PRF_LEN   = 6,
    parameter int unsigned ROB_LEN   = 5,
    parameter int unsigned FU_ID_W   = $clog2(NUM_FU)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [NUM_FU-1:0]              fu_valid,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic [NUM_FU*XLEN-1:0]         fu_value,
    input  logic [NUM_FU*PRF_LEN-1:0]      fu_prf_idx,
    input  logic [NUM_FU*ROB_LEN-1:0]      fu_rob_idx,
    input  logic [NUM_FU*XLEN-1:0]         fu_PC,
    input  logic [NUM_FU-1:0]              fu_is_br,
    input  logic [NUM_FU-1:0]              fu_br_dir,
    input  logic [NUM_FU*XLEN-1:0]         fu_br_target,
    input  logic [NUM_FU-1:0]              fu_mis_pred,
    output logic [CDB_WIDTH-1:0]           cdb_valid,
    output logic [CDB_WIDTH*XLEN-1:0]      cdb_value,
    output logic [CDB_WIDTH*PRF_LEN-1:0]   cdb_prf_idx,
    output logic [CDB_WIDTH*ROB_LEN-1:0]   cdb_rob_idx,
    output logic [CDB_WIDTH*XLEN-1:0]      cdb_PC,
    output logic [CDB_WIDTH*FU_ID_W-1:0]   cdb_fu_id,
    output logic [CDB_WIDTH-1:0]           cdb_is_br,
    output logic [CDB_WIDTH-1:0]           cdb_br_dir,
    output logic [CDB_WIDTH-1:0]           cdb_mis_pred,
    output logic [CDB_WIDTH*XLEN-1:0]      cdb_br_target
);

    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned LCNT_W = $clog2(CDB_WIDTH + 1);
    localparam int unsigned LANE_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;
    localparam int unsigned CAND_W = FU_ID_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    pc;
        logic               is_br;
        logic               br_dir;
        logic [XLEN-1:0]    br_target;
        logic               mis_pred;
    } pkt_t;

    pkt_t               r_mem [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr [NUM_FU];
    logic [PTR_W-1:0]   r_rd_ptr [NUM_FU];
    logic [CNT_W-1:0]   r_count [NUM_FU];
    logic [FU_ID_W-1:0] r_rr_ptr;

    logic [CDB_WIDTH-1:0]         r_cdb_valid;
    logic [CDB_WIDTH*XLEN-1:0]    r_cdb_value;
    logic [CDB_WIDTH*PRF_LEN-1:0] r_cdb_prf_idx;
    logic [CDB_WIDTH*ROB_LEN-1:0] r_cdb_rob_idx;
    logic [CDB_WIDTH*XLEN-1:0]    r_cdb_pc;
    logic [CDB_WIDTH*FU_ID_W-1:0] r_cdb_fu_id;
    logic [CDB_WIDTH-1:0]         r_cdb_is_br;
    logic [CDB_WIDTH-1:0]         r_cdb_br_dir;
    logic [CDB_WIDTH-1:0]         r_cdb_mis_pred;
    logic [CDB_WIDTH*XLEN-1:0]    r_cdb_br_target;

    pkt_t               w_in_pkt [NUM_FU];
    pkt_t               w_head [NUM_FU];
    logic [NUM_FU-1:0]  w_nonempty;
    logic [NUM_FU-1:0]  w_full;
    logic [NUM_FU-1:0]  w_pri;
    logic [NUM_FU-1:0]  w_enq;
    logic [NUM_FU-1:0]  w_grant;
    logic [CDB_WIDTH-1:0] w_lane_vld;
    logic [FU_ID_W-1:0] w_lane_sel [CDB_WIDTH];
    pkt_t               w_lane_pkt [CDB_WIDTH];
    logic [FU_ID_W-1:0] w_last_fu;
    logic               w_any_grant;

    // Unpack FU inputs and derive per-FIFO head, occupancy and arbitration class.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_in_pkt[i].value     = fu_value[i*XLEN +: XLEN];
            w_in_pkt[i].prf_idx   = fu_prf_idx[i*PRF_LEN +: PRF_LEN];
            w_in_pkt[i].rob_idx   = fu_rob_idx[i*ROB_LEN +: ROB_LEN];
            w_in_pkt[i].pc        = fu_PC[i*XLEN +: XLEN];
            w_in_pkt[i].is_br     = fu_is_br[i];
            w_in_pkt[i].br_dir    = fu_br_dir[i];
            w_in_pkt[i].br_target = fu_br_target[i*XLEN +: XLEN];
            w_in_pkt[i].mis_pred  = fu_mis_pred[i];
            w_head[i]             = r_mem[i][r_rd_ptr[i]];
            w_nonempty[i]         = (r_count[i] != '0);
            w_full[i]             = (r_count[i] == CNT_W'(BUF_DEPTH));
`ifdef CDB_BR_PRIORITY_EN
            w_pri[i]              = w_head[i].is_br;
`else
            w_pri[i]              = 1'b0;
`endif
        end
    end

    // Ready comes only from the registered count; held low during reset.
    assign fu_ready = ~w_full & {NUM_FU{~reset}};
    assign w_enq    = fu_valid & fu_ready & {NUM_FU{~flush}};

    // Two scans from rr_ptr: high-priority heads first, then the rest; lanes fill from 0.
    always_comb begin
        logic [CAND_W-1:0]  cand;
        logic [FU_ID_W-1:0] idx;
        logic [LCNT_W-1:0]  n;
        w_grant     = '0;
        w_lane_vld  = '0;
        w_last_fu   = r_rr_ptr;
        w_any_grant = 1'b0;
        cand        = '0;
        idx         = '0;
        n           = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            w_lane_sel[k] = '0;
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                cand = {1'b0, r_rr_ptr} + CAND_W'(j);
                if (cand >= CAND_W'(NUM_FU)) begin
                    cand = cand - CAND_W'(NUM_FU);
                end
                idx = cand[FU_ID_W-1:0];
                if (w_nonempty[idx] && (w_pri[idx] == (pass == 0)) &&
                    (n < LCNT_W'(CDB_WIDTH))) begin
                    w_grant[idx]                  = 1'b1;
                    w_lane_vld[n[LANE_W-1:0]]     = 1'b1;
                    w_lane_sel[n[LANE_W-1:0]]     = idx;
                    w_last_fu                     = idx;
                    w_any_grant                   = 1'b1;
                    n                             = n + LCNT_W'(1);
                end
            end
        end
    end

    // Select the granted head packet for each lane; idle lanes carry zeros.
    always_comb begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
            w_lane_pkt[k] = w_lane_vld[k] ? w_head[w_lane_sel[k]] : '0;
        end
    end

    // FIFO storage; entries are only meaningful while counted, so no reset needed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_enq[i]) begin
                r_mem[i][r_wr_ptr[i]] <= w_in_pkt[i];
            end
        end
    end

    // FIFO pointers, occupancy and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_enq[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_grant[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                r_count[i] <= r_count[i] + CNT_W'(w_enq[i]) - CNT_W'(w_grant[i]);
            end
            if (w_any_grant) begin
                r_rr_ptr <= (w_last_fu == FU_ID_W'(NUM_FU - 1)) ? '0 : w_last_fu + FU_ID_W'(1);
            end
        end
    end

    // Broadcast lane registers.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_cdb_valid     <= '0;
            r_cdb_value     <= '0;
            r_cdb_prf_idx   <= '0;
            r_cdb_rob_idx   <= '0;
            r_cdb_pc        <= '0;
            r_cdb_fu_id     <= '0;
            r_cdb_is_br     <= '0;
            r_cdb_br_dir    <= '0;
            r_cdb_mis_pred  <= '0;
            r_cdb_br_target <= '0;
        end else begin
            r_cdb_valid <= w_lane_vld;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                r_cdb_value[k*XLEN +: XLEN]         <= w_lane_pkt[k].value;
                r_cdb_prf_idx[k*PRF_LEN +: PRF_LEN] <= w_lane_pkt[k].prf_idx;
                r_cdb_rob_idx[k*ROB_LEN +: ROB_LEN] <= w_lane_pkt[k].rob_idx;
                r_cdb_pc[k*XLEN +: XLEN]            <= w_lane_pkt[k].pc;
                r_cdb_fu_id[k*FU_ID_W +: FU_ID_W]   <= w_lane_sel[k];
                r_cdb_is_br[k]                      <= w_lane_pkt[k].is_br;
                r_cdb_br_dir[k]                     <= w_lane_pkt[k].br_dir;
                r_cdb_mis_pred[k]                   <= w_lane_pkt[k].mis_pred;
                r_cdb_br_target[k*XLEN +: XLEN]     <= w_lane_pkt[k].br_target;
            end
        end
    end

    assign cdb_valid     = r_cdb_valid;
    assign cdb_value     = r_cdb_value;
    assign cdb_prf_idx   = r_cdb_prf_idx;
    assign cdb_rob_idx   = r_cdb_rob_idx;
    assign cdb_PC        = r_cdb_pc;
    assign cdb_fu_id     = r_cdb_fu_id;
    assign cdb_is_br     = r_cdb_is_br;
    assign cdb_br_dir    = r_cdb_br_dir;
    assign cdb_mis_pred  = r_cdb_mis_pred;
    assign cdb_br_target = r_cdb_br_target;

endmodule

// File: tb/tb_cdb_rr_multilane.sv
// tb_cdb_rr_multilane: scoreboard bench for cdb_rr_multilane.
// A queue-based reference model predicts each cycle's lanes; a negedge monitor compares.
module tb_cdb_rr_multilane;

    localparam int unsigned NUM_FU    = 4;
    localparam int unsigned CDB_WIDTH = 2;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned PRF_LEN   = 6;
    localparam int unsigned ROB_LEN   = 5;
    localparam int unsigned FU_ID_W   = 2;
    localparam int unsigned LW        = 128;

    typedef struct packed {
        logic [31:0] value;
        logic [5:0]  prf;
        logic [4:0]  rob;
        logic [31:0] pc;
        logic        is_br;
        logic        dir;
        logic [31:0] tgt;
        logic        mis;
    } tpkt_t;

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         flush;
    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU-1:0]            fu_ready;
    logic [NUM_FU*XLEN-1:0]       fu_value;
    logic [NUM_FU*PRF_LEN-1:0]    fu_prf_idx;
    logic [NUM_FU*ROB_LEN-1:0]    fu_rob_idx;
    logic [NUM_FU*XLEN-1:0]       fu_PC;
    logic [NUM_FU-1:0]            fu_is_br;
    logic [NUM_FU-1:0]            fu_br_dir;
    logic [NUM_FU*XLEN-1:0]       fu_br_target;
    logic [NUM_FU-1:0]            fu_mis_pred;
    logic [CDB_WIDTH-1:0]         cdb_valid;
    logic [CDB_WIDTH*XLEN-1:0]    cdb_value;
    logic [CDB_WIDTH*PRF_LEN-1:0] cdb_prf_idx;
    logic [CDB_WIDTH*ROB_LEN-1:0] cdb_rob_idx;
    logic [CDB_WIDTH*XLEN-1:0]    cdb_PC;
    logic [CDB_WIDTH*FU_ID_W-1:0] cdb_fu_id;
    logic [CDB_WIDTH-1:0]         cdb_is_br;
    logic [CDB_WIDTH-1:0]         cdb_br_dir;
    logic [CDB_WIDTH-1:0]         cdb_mis_pred;
    logic [CDB_WIDTH*XLEN-1:0]    cdb_br_target;

    int total = 0;
    int bad   = 0;

    tpkt_t                     mq [NUM_FU][$];
    int                        m_rr = 0;
    logic [NUM_FU-1:0]         acc  = '0;
    logic [CDB_WIDTH*LW-1:0]   exp_q [$];

    logic [NUM_FU-1:0]         cur_v = '0;
    tpkt_t                     cur_p [NUM_FU];
    int                        seq = 0;

    cdb_rr_multilane #(
        .NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH), .BUF_DEPTH(BUF_DEPTH), .XLEN(XLEN),
        .PRF_LEN(PRF_LEN), .ROB_LEN(ROB_LEN), .FU_ID_W(FU_ID_W)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_value(fu_value),
        .fu_prf_idx(fu_prf_idx), .fu_rob_idx(fu_rob_idx), .fu_PC(fu_PC),
        .fu_is_br(fu_is_br), .fu_br_dir(fu_br_dir), .fu_br_target(fu_br_target),
        .fu_mis_pred(fu_mis_pred),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_prf_idx(cdb_prf_idx),
        .cdb_rob_idx(cdb_rob_idx), .cdb_PC(cdb_PC), .cdb_fu_id(cdb_fu_id),
        .cdb_is_br(cdb_is_br), .cdb_br_dir(cdb_br_dir), .cdb_mis_pred(cdb_mis_pred),
        .cdb_br_target(cdb_br_target)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] lw(input logic v, input logic [FU_ID_W-1:0] id, input tpkt_t p);
        return {15'd0, v, id, p};
    endfunction

    function automatic tpkt_t mk(input logic [31:0] value, input logic [5:0] prf, input logic [4:0] rob,
                                 input logic [31:0] pc, input logic is_br, input logic dir,
                                 input logic [31:0] tgt, input logic mis);
        tpkt_t p;
        p.value = value; p.prf = prf; p.rob = rob; p.pc = pc;
        p.is_br = is_br; p.dir = dir; p.tgt = tgt; p.mis = mis;
        return p;
    endfunction

    function automatic tpkt_t rnd_pkt(input int s);
        tpkt_t p;
        p.value = {16'($urandom), 16'(s)};
        p.prf   = 6'($urandom);
        p.rob   = 5'($urandom);
        p.pc    = $urandom;
        p.is_br = ($urandom_range(0, 3) == 0);
        p.dir   = 1'($urandom);
        p.tgt   = $urandom;
        p.mis   = 1'($urandom);
        return p;
    endfunction

    function automatic tpkt_t pin_pkt(input int i);
        tpkt_t p;
        p.value = fu_value[i*XLEN +: XLEN];
        p.prf   = fu_prf_idx[i*PRF_LEN +: PRF_LEN];
        p.rob   = fu_rob_idx[i*ROB_LEN +: ROB_LEN];
        p.pc    = fu_PC[i*XLEN +: XLEN];
        p.is_br = fu_is_br[i];
        p.dir   = fu_br_dir[i];
        p.tgt   = fu_br_target[i*XLEN +: XLEN];
        p.mis   = fu_mis_pred[i];
        return p;
    endfunction

    function automatic tpkt_t lane_pkt(input int k);
        tpkt_t p;
        p.value = cdb_value[k*XLEN +: XLEN];
        p.prf   = cdb_prf_idx[k*PRF_LEN +: PRF_LEN];
        p.rob   = cdb_rob_idx[k*ROB_LEN +: ROB_LEN];
        p.pc    = cdb_PC[k*XLEN +: XLEN];
        p.is_br = cdb_is_br[k];
        p.dir   = cdb_br_dir[k];
        p.tgt   = cdb_br_target[k*XLEN +: XLEN];
        p.mis   = cdb_mis_pred[k];
        return p;
    endfunction

    task automatic apply();
        for (int i = 0; i < NUM_FU; i++) begin
            fu_valid[i]                       = cur_v[i];
            fu_value[i*XLEN +: XLEN]          = cur_p[i].value;
            fu_prf_idx[i*PRF_LEN +: PRF_LEN]  = cur_p[i].prf;
            fu_rob_idx[i*ROB_LEN +: ROB_LEN]  = cur_p[i].rob;
            fu_PC[i*XLEN +: XLEN]             = cur_p[i].pc;
            fu_is_br[i]                       = cur_p[i].is_br;
            fu_br_dir[i]                      = cur_p[i].dir;
            fu_br_target[i*XLEN +: XLEN]      = cur_p[i].tgt;
            fu_mis_pred[i]                    = cur_p[i].mis;
        end
    endtask

    // Drive current offers, take one edge; accepted offers retire, flush/reset drop them.
    task automatic tick();
        apply();
        @(posedge clock);
        #2;
        if (reset || flush) cur_v = '0;
        else cur_v = cur_v & ~acc;
    endtask

    // Reference model: rotated FU order, optional branch-first, first CDB_WIDTH non-empty win.
    always @(posedge clock) begin : model
        logic [CDB_WIDTH*LW-1:0] e;
        logic [NUM_FU-1:0]       a;
        int                      order[$];
        int                      cand[$];
        int                      n;
        e = '0;
        a = '0;
        order.delete();
        cand.delete();
        if (reset || flush) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_rr = 0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) a[i] = fu_valid[i] && (mq[i].size() < BUF_DEPTH);
            for (int j = 0; j < NUM_FU; j++) order.push_back((m_rr + j) % NUM_FU);
`ifdef CDB_BR_PRIORITY_EN
            foreach (order[j]) if (mq[order[j]].size() > 0 && mq[order[j]][0].is_br) cand.push_back(order[j]);
            foreach (order[j]) if (mq[order[j]].size() > 0 && !mq[order[j]][0].is_br) cand.push_back(order[j]);
`else
            foreach (order[j]) if (mq[order[j]].size() > 0) cand.push_back(order[j]);
`endif
            n = (cand.size() < CDB_WIDTH) ? cand.size() : CDB_WIDTH;
            for (int k = 0; k < n; k++) e[k*LW +: LW] = lw(1'b1, FU_ID_W'(cand[k]), mq[cand[k]].pop_front());
            if (n > 0) m_rr = (cand[n-1] + 1) % NUM_FU;
            for (int i = 0; i < NUM_FU; i++) if (a[i]) mq[i].push_back(pin_pkt(i));
        end
        acc = a;
        exp_q.push_back(e);
    end

    // Monitor: compare registered lanes and ready against the model every cycle.
    always @(negedge clock) begin : monitor
        logic [CDB_WIDTH*LW-1:0] e;
        logic [NUM_FU-1:0]       r;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < CDB_WIDTH; k++) begin
                check($sformatf("lane%0d", k),
                      lw(cdb_valid[k], cdb_fu_id[k*FU_ID_W +: FU_ID_W], lane_pkt(k)), e[k*LW +: LW]);
            end
            for (int i = 0; i < NUM_FU; i++) r[i] = !reset && (mq[i].size() < BUF_DEPTH);
            check("fu_ready", LW'(fu_ready), LW'(r));
        end
    end

    initial begin : stim
        logic saw;
        int   sent2;
        reset = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < NUM_FU; i++) cur_p[i] = '0;
        apply();
        repeat (3) tick();
        check("reset_valid", LW'(cdb_valid), LW'(0));
        check("reset_ready", LW'(fu_ready), LW'(0));
        reset = 1'b0;
        tick();

        // basic path
        cur_p[0] = mk(32'h11, 6'd3, 5'd2, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        cur_v[0] = 1'b1;
        tick();
        check("basic_not_early", LW'(cdb_valid), LW'(2'b00));
        tick();
        check("basic_valid", LW'(cdb_valid), LW'(2'b01));
        check("basic_value", LW'(cdb_value[31:0]), LW'(32'h11));
        check("basic_prf", LW'(cdb_prf_idx[5:0]), LW'(6'd3));
        check("basic_rob", LW'(cdb_rob_idx[4:0]), LW'(5'd2));
        check("basic_fu_id", LW'(cdb_fu_id[1:0]), LW'(2'd0));

        // contention and rotation from rr_ptr = 0
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            cur_p[i] = mk(32'h20 + 32'(i), 6'(i), 5'(i), 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        cur_v = '1;
        tick();
        tick();
        check("cont_a_valid", LW'(cdb_valid), LW'(2'b11));
        check("cont_a_ids", LW'(cdb_fu_id), LW'(4'b0100));
        tick();
        check("cont_b_ids", LW'(cdb_fu_id), LW'(4'b1110));

        // backpressure on FU2 while FU0/FU1 keep both lanes busy
        flush = 1'b1; tick(); flush = 1'b0;
        saw = 1'b0;
        sent2 = 0;
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!cur_v[i]) begin
                    cur_p[i] = mk(32'h1000 + 32'(seq), 6'd1, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
                    seq++;
                    cur_v[i] = 1'b1;
                end
            end
            if (!cur_v[2] && sent2 < 3) begin
                cur_p[2] = mk(32'h300 + 32'(sent2), 6'd2, 5'd2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
                cur_v[2] = 1'b1;
                sent2++;
            end
            tick();
            if (!fu_ready[2]) saw = 1'b1;
        end
        check("bp_ready_dropped", LW'(saw), LW'(1'b1));
        cur_v = '0;
        repeat (6) tick();

        // flush with FU1 packets buffered and FU3 offering
        cur_p[1] = mk(32'h400, 6'd4, 5'd4, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cur_v[1] = 1'b1;
        tick();
        cur_p[1] = mk(32'h401, 6'd4, 5'd5, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cur_v[1] = 1'b1;
        tick();
        flush = 1'b1;
        cur_p[3] = mk(32'h403, 6'd7, 5'd7, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cur_v[3] = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", LW'(cdb_valid), LW'(2'b00));
        check("flush_ready", LW'(fu_ready), LW'(4'hF));
        tick();
        check("flush_after", LW'(cdb_valid), LW'(2'b00));

        // branch sideband
        cur_p[3] = mk(32'h55, 6'd9, 5'd9, 32'h300, 1'b1, 1'b1, 32'h2000, 1'b1);
        cur_v[3] = 1'b1;
        tick();
        tick();
        check("br_lane0", LW'({cdb_valid[0], cdb_is_br[0], cdb_br_dir[0], cdb_mis_pred[0]}), LW'(4'hF));
        check("br_target", LW'(cdb_br_target[31:0]), LW'(32'h2000));
        check("br_fu_id", LW'(cdb_fu_id[1:0]), LW'(2'd3));

`ifdef CDB_BR_PRIORITY_EN
        // branch head jumps the round-robin order
        flush = 1'b1; tick(); flush = 1'b0;
        cur_p[0] = mk(32'h60, 6'd1, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cur_p[1] = mk(32'h61, 6'd2, 5'd2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cur_p[3] = mk(32'h63, 6'd3, 5'd3, 32'h0, 1'b1, 1'b0, 32'h40, 1'b0);
        cur_v = 4'b1011;
        tick();
        tick();
        check("brpri_ids", LW'(cdb_fu_id), LW'(4'b0011));
`endif

        // randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!cur_v[i] && $urandom_range(0, 2) == 0) begin
                    cur_p[i] = rnd_pkt(seq);
                    seq++;
                    cur_v[i] = 1'b1;
                end
            end
            flush = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        flush = 1'b0;
        reset = 1'b0;
        cur_v = '0;
        repeat (8) tick();
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
